// File: rtl/sync_fifo_wr_arb.sv
// Round-robin write arbiter sharing one sync FIFO write port between NREQ producers.
// Packets are never interleaved, and a write is only issued when the FIFO has room for it.
module sync_fifo_wr_arb #(
  parameter int WIDTH = 32,
  parameter int DLOG2 = 3,
  parameter int NREQ  = 4,
  parameter int IDXW  = 2
) (
  input  logic                    clock,
  input  logic                    aclr,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_last,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [WIDTH-1:0]        fifo_data,
  output logic                    fifo_wrreq,
  input  logic [DLOG2-1:0]        fifo_usedw,
  output logic                    locked,
  output logic [IDXW-1:0]         owner
);

  localparam logic [DLOG2:0] MAXOCC = (DLOG2+1)'((1 << DLOG2) - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic              locked_q, locked_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              wrreq_q, wrreq_d;

  logic [DLOG2:0]    occ;
  logic              space;
  logic [NREQ-1:0]   rotValid;
  logic [IDXW-1:0]   rrOffset;
  logic [IDXW:0]     rrSum;
  logic [IDXW-1:0]   rrIdx;
  logic              rrAny;
  logic [IDXW-1:0]   gntIdx;
  logic              gntOn;
  logic              selValid;
  logic              selLast;
  logic [WIDTH-1:0]  selData;
  logic              accept;

  // A write registered this cycle is not yet in usedw, so it counts as occupied.
  assign occ   = {1'b0, fifo_usedw} + {{DLOG2{1'b0}}, wrreq_q};
  assign space = (occ < MAXOCC);

  // Rotating the doubled valid vector puts the pointer's requester at bit 0.
  assign rotValid = NREQ'({req_valid, req_valid} >> ptr_q);

  always_comb begin
    rrOffset = '0;
    rrAny    = 1'b0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rotValid[j]) begin
        rrAny    = 1'b1;
        rrOffset = IDXW'(j);
      end
    end
    rrSum = {1'b0, ptr_q} + {1'b0, rrOffset};
    if (rrSum >= (IDXW+1)'(NREQ)) begin
      rrSum = rrSum - (IDXW+1)'(NREQ);
    end
    rrIdx = rrSum[IDXW-1:0];
  end

  assign gntIdx = (state_q == LOCKED) ? owner_q : rrIdx;
  assign gntOn  = (state_q == LOCKED) | rrAny;

  always_comb begin
    req_ready = '0;
    selValid  = 1'b0;
    selLast   = 1'b0;
    selData   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDXW'(i) == gntIdx) begin
        selValid     = req_valid[i];
        selLast      = req_last[i];
        selData      = req_data[i*WIDTH +: WIDTH];
        req_ready[i] = gntOn & space & ~aclr;
      end
    end
  end

  assign accept = selValid & gntOn & space & ~aclr;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    locked_d = locked_q;
    data_d   = data_q;
    wrreq_d  = 1'b0;
    if (accept) begin
      data_d  = selData;
      wrreq_d = 1'b1;
      owner_d = gntIdx;
      if (selLast) begin
        state_d  = IDLE;
        locked_d = 1'b0;
        ptr_d    = (gntIdx == IDXW'(NREQ - 1)) ? '0 : gntIdx + IDXW'(1);
      end else begin
        state_d  = LOCKED;
        locked_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      locked_q <= 1'b0;
      data_q   <= '0;
      wrreq_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      locked_q <= locked_d;
      data_q   <= data_d;
      wrreq_q  <= wrreq_d;
    end
  end

  assign fifo_data  = data_q;
  assign fifo_wrreq = wrreq_q;
  assign locked     = locked_q;
  assign owner      = owner_q;

endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// Bench for sync_fifo_wr_arb: a FIFO occupancy model plus a write-data scoreboard,
// driven by one task per scenario.
module tb_sync_fifo_wr_arb;

  localparam int WIDTH = 32;
  localparam int DLOG2 = 3;
  localparam int NREQ  = 4;
  localparam int IDXW  = 2;

  logic              clock = 1'b0;
  logic              aclr;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_last;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [WIDTH-1:0]  fifo_data;
  logic              fifo_wrreq;
  logic [DLOG2-1:0]  fifo_usedw;
  logic              locked;
  logic [IDXW-1:0]   owner;

  int total = 0;
  int bad = 0;
  int fifoCount = 0;
  logic rdEn = 1'b0;
  logic [WIDTH-1:0] expQ[$];

  assign fifo_usedw = DLOG2'(fifoCount);

  always #5 clock = ~clock;

  sync_fifo_wr_arb #(.WIDTH(WIDTH), .DLOG2(DLOG2), .NREQ(NREQ), .IDXW(IDXW)) dut (
    .clock      (clock),
    .aclr       (aclr),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_data  (fifo_data),
    .fifo_wrreq (fifo_wrreq),
    .fifo_usedw (fifo_usedw),
    .locked     (locked),
    .owner      (owner)
  );

  // One clock: scoreboard the pending write at negedge, then commit it to the FIFO model after the edge.
  task automatic tick();
    logic pendWr;
    logic [WIDTH-1:0] e;
    int n;
    @(negedge clock);
    pendWr = fifo_wrreq;
    if (pendWr) begin
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL sb_unexpected_write got=%h expected=none", fifo_data);
      end else begin
        e = expQ.pop_front();
        if (fifo_data !== e) begin
          bad++;
          $display("[TB] FAIL sb_data got=%h expected=%h", fifo_data, e);
        end
      end
    end
    @(posedge clock);
    #1;
    n = fifoCount;
    if (rdEn && n > 0) n--;
    if (pendWr) begin
      total++;
      if (n >= 7) begin
        bad++;
        $display("[TB] FAIL overflow count=%0d expected_max=7", n + 1);
      end else begin
        n++;
      end
    end
    fifoCount = n;
  endtask

  task automatic setReq(input int i, input logic v, input logic l, input logic [WIDTH-1:0] d);
    req_valid[i] = v;
    req_last[i]  = l;
    req_data[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic applyReset();
    req_valid = '0;
    aclr = 1'b1;
    tick();
    aclr = 1'b0;
    expQ.delete();
  endtask

  task automatic drain();
    int k;
    req_valid = '0;
    rdEn = 1'b1;
    k = 0;
    while ((fifoCount != 0 || fifo_wrreq) && k < 40) begin
      tick();
      k++;
    end
    rdEn = 1'b0;
    total++;
    if (fifoCount != 0 || fifo_wrreq) begin
      bad++;
      $display("[TB] FAIL drain_timeout count=%0d expected=0", fifoCount);
    end
  endtask

  task automatic test_reset();
    aclr = 1'b1;
    req_valid = '1;
    req_last  = '1;
    req_data  = {32'hD3, 32'hC2, 32'hB1, 32'hA0};
    tick();
    tick();
    total++; if (fifo_wrreq !== 1'b0) begin bad++; $display("[TB] FAIL rst_wrreq got=%b expected=0", fifo_wrreq); end
    total++; if (fifo_data !== '0) begin bad++; $display("[TB] FAIL rst_data got=%h expected=0", fifo_data); end
    total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL rst_locked got=%b expected=0", locked); end
    total++; if (owner !== 2'd0) begin bad++; $display("[TB] FAIL rst_owner got=%0d expected=0", owner); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL rst_ready got=%b expected=0000", req_ready); end
    req_valid = '0;
    aclr = 1'b0;
    tick();
    total++; if (req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL idle_ready got=%b expected=0000", req_ready); end
  endtask

  task automatic test_single_beats();
    applyReset();
    setReq(0, 1'b1, 1'b1, 32'hA0);
    setReq(2, 1'b1, 1'b1, 32'hC0);
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("[TB] FAIL sb1_ready got=%b expected=0001", req_ready); end
    expQ.push_back(32'hA0);
    tick();
    setReq(0, 1'b0, 1'b0, 32'h0);
    total++; if (fifo_wrreq !== 1'b1) begin bad++; $display("[TB] FAIL sb1_wrreq got=%b expected=1", fifo_wrreq); end
    total++; if (owner !== 2'd0) begin bad++; $display("[TB] FAIL sb1_owner got=%0d expected=0", owner); end
    total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL sb1_locked got=%b expected=0", locked); end
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("[TB] FAIL sb2_ready got=%b expected=0100", req_ready); end
    expQ.push_back(32'hC0);
    tick();
    setReq(2, 1'b0, 1'b0, 32'h0);
    total++; if (owner !== 2'd2) begin bad++; $display("[TB] FAIL sb2_owner got=%0d expected=2", owner); end
    // Pointer should now sit at 3: with 0 and 3 both valid, 3 wins.
    setReq(0, 1'b1, 1'b1, 32'hB0);
    setReq(3, 1'b1, 1'b1, 32'hD0);
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("[TB] FAIL ptr3_ready got=%b expected=1000", req_ready); end
    req_valid = '0;
    tick();
    tick();
    total++; if (fifo_wrreq !== 1'b0) begin bad++; $display("[TB] FAIL sb_idle_wrreq got=%b expected=0", fifo_wrreq); end
    drain();
  endtask

  task automatic test_fill();
    int beat[NREQ];
    int g;
    applyReset();
    for (int i = 0; i < NREQ; i++) begin
      beat[i] = 0;
      setReq(i, 1'b1, 1'b1, 32'h100 * (i + 1));
    end
    for (int k = 0; k < 7; k++) begin
      g = k % NREQ;
      #1;
      total++; if (req_ready !== 4'(1 << g)) begin bad++; $display("[TB] FAIL fill_ready%0d got=%b expected=%b", k, req_ready, 4'(1 << g)); end
      expQ.push_back(32'h100 * (g + 1) + beat[g]);
      tick();
      beat[g]++;
      setReq(g, 1'b1, 1'b1, 32'h100 * (g + 1) + beat[g]);
    end
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL fill_stop_ready got=%b expected=0000", req_ready); end
    tick();
    total++; if (fifo_wrreq !== 1'b0) begin bad++; $display("[TB] FAIL fill_stop_wrreq got=%b expected=0", fifo_wrreq); end
    total++; if (fifoCount != 7) begin bad++; $display("[TB] FAIL fill_count got=%0d expected=7", fifoCount); end
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL fill_full_ready got=%b expected=0000", req_ready); end
    tick();
    total++; if (fifo_wrreq !== 1'b0) begin bad++; $display("[TB] FAIL fill_full_wrreq got=%b expected=0", fifo_wrreq); end
    drain();
  endtask

  task automatic test_locked();
    applyReset();
    setReq(1, 1'b1, 1'b0, 32'h11);
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("[TB] FAIL lk1_ready got=%b expected=0010", req_ready); end
    expQ.push_back(32'h11);
    tick();
    total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL lk1_locked got=%b expected=1", locked); end
    total++; if (owner !== 2'd1) begin bad++; $display("[TB] FAIL lk1_owner got=%0d expected=1", owner); end
    // Owner stalls while requester 0 waits: the port must stay with owner 1.
    setReq(0, 1'b1, 1'b1, 32'hA5);
    setReq(1, 1'b0, 1'b0, 32'h0);
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("[TB] FAIL stall_ready got=%b expected=0010", req_ready); end
    tick();
    total++; if (fifo_wrreq !== 1'b0) begin bad++; $display("[TB] FAIL stall_wrreq got=%b expected=0", fifo_wrreq); end
    total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL stall_locked got=%b expected=1", locked); end
    setReq(1, 1'b1, 1'b0, 32'h12);
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("[TB] FAIL lk2_ready got=%b expected=0010", req_ready); end
    expQ.push_back(32'h12);
    tick();
    total++; if (locked !== 1'b1 || owner !== 2'd1) begin bad++; $display("[TB] FAIL lk2_state got=%b/%0d expected=1/1", locked, owner); end
    setReq(1, 1'b1, 1'b1, 32'h13);
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("[TB] FAIL lk3_ready got=%b expected=0010", req_ready); end
    expQ.push_back(32'h13);
    tick();
    setReq(1, 1'b0, 1'b0, 32'h0);
    total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL lk3_unlock got=%b expected=0", locked); end
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("[TB] FAIL lk_next_ready got=%b expected=0001", req_ready); end
    expQ.push_back(32'hA5);
    tick();
    setReq(0, 1'b0, 1'b0, 32'h0);
    total++; if (owner !== 2'd0) begin bad++; $display("[TB] FAIL lk_next_owner got=%0d expected=0", owner); end
    drain();
  endtask

  task automatic test_occupancy();
    applyReset();
    for (int k = 0; k < 6; k++) begin
      setReq(0, 1'b1, 1'b1, 32'h60 + k);
      #1;
      total++; if (req_ready !== 4'b0001) begin bad++; $display("[TB] FAIL occ_pre%0d_ready got=%b expected=0001", k, req_ready); end
      expQ.push_back(32'h60 + k);
      tick();
    end
    setReq(0, 1'b0, 1'b0, 32'h0);
    tick();
    total++; if (fifoCount != 6 || fifo_wrreq !== 1'b0) begin bad++; $display("[TB] FAIL occ6_setup got=%0d/%b expected=6/0", fifoCount, fifo_wrreq); end
    setReq(0, 1'b1, 1'b1, 32'h66);
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("[TB] FAIL occ6_ready got=%b expected=0001", req_ready); end
    expQ.push_back(32'h66);
    tick();
    setReq(0, 1'b1, 1'b1, 32'h67);
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL occ7_ready got=%b expected=0000", req_ready); end
    tick();
    total++; if (fifo_wrreq !== 1'b0) begin bad++; $display("[TB] FAIL occ7_wrreq got=%b expected=0", fifo_wrreq); end
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL full_ready got=%b expected=0000", req_ready); end
    rdEn = 1'b1;
    tick();
    rdEn = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("[TB] FAIL pop_ready got=%b expected=0001", req_ready); end
    expQ.push_back(32'h67);
    tick();
    setReq(0, 1'b0, 1'b0, 32'h0);
    drain();
  endtask

  task automatic test_reset_midpacket();
    applyReset();
    setReq(2, 1'b1, 1'b0, 32'h21);
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("[TB] FAIL mid_ready got=%b expected=0100", req_ready); end
    tick();
    total++; if (locked !== 1'b1 || owner !== 2'd2) begin bad++; $display("[TB] FAIL mid_state got=%b/%0d expected=1/2", locked, owner); end
    // The accepted beat is abandoned by the reset, so it is never expected in the FIFO.
    aclr = 1'b1;
    setReq(2, 1'b1, 1'b0, 32'h22);
    setReq(1, 1'b1, 1'b1, 32'h31);
    #1;
    total++; if (fifo_wrreq !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_wrreq got=%b expected=0", fifo_wrreq); end
    total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_locked got=%b expected=0", locked); end
    total++; if (owner !== 2'd0) begin bad++; $display("[TB] FAIL mid_rst_owner got=%0d expected=0", owner); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL mid_rst_ready got=%b expected=0000", req_ready); end
    tick();
    aclr = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("[TB] FAIL post_rst_ready got=%b expected=0010", req_ready); end
    expQ.push_back(32'h31);
    tick();
    req_valid = '0;
    total++; if (owner !== 2'd1 || locked !== 1'b0) begin bad++; $display("[TB] FAIL post_rst_state got=%0d/%b expected=1/0", owner, locked); end
    drain();
  endtask

  initial begin
    aclr      = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    test_reset();
    test_single_beats();
    test_fill();
    test_locked();
    test_occupancy();
    test_reset_midpacket();
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL sb_leftover got=%0d expected=0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
